// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared ALU selects, op encodings and sequencer states (MULDIV_SIGNED_EN adds PRE/POST)
package muldiv_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
`ifdef MULDIV_SIGNED_EN
        ST_PRE  = 3'd4,
        ST_POST = 3'd5,
`endif
        ST_DONE = 3'd3
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - EX-stage combinational ALU shared with the multiply/divide sequencer
module alu
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring-divide iteration around the borrowed ALU
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] alu_result,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] hi_nx,
    output logic [WIDTH-1:0] lo_nx
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] sh_hi;
    logic             carry;
    logic             no_borrow;

    // Carry/borrow are rebuilt from operand and result sign bits since the ALU exports neither.
    always_comb begin
        sh_hi     = {hi[M-1:0], lo[M]};
        carry     = 1'b0;
        no_borrow = 1'b0;
        alu_sel   = ALU_ADD;
        alu_a     = hi;
        alu_b     = opnd;
        hi_nx     = hi;
        lo_nx     = lo;
        if (is_div) begin
            alu_sel   = ALU_SUB;
            alu_a     = sh_hi;
            no_borrow = (sh_hi[M] & ~opnd[M]) | ((sh_hi[M] | ~opnd[M]) & ~alu_result[M]);
            if (hi[M] | no_borrow) begin
                hi_nx = alu_result;
                lo_nx = {lo[M-1:0], 1'b1};
            end else begin
                hi_nx = sh_hi;
                lo_nx = {lo[M-1:0], 1'b0};
            end
        end else begin
            carry = (hi[M] & opnd[M]) | ((hi[M] | opnd[M]) & ~alu_result[M]);
            if (lo[0]) begin
                hi_nx = {carry, alu_result[M:1]};
                lo_nx = {alu_result[0], lo[M:1]};
            end else begin
                hi_nx = {1'b0, hi[M:1]};
                lo_nx = {hi[0], lo[M:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU sequencer driving the EX ALU; MULDIV_SIGNED_EN adds MULT/DIV
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] hi_r, lo_r, opnd;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             start_div, div_zero;
    logic [2:0]       step_sel;
    logic [WIDTH-1:0] step_a, step_b, step_hi, step_lo;

    assign start_div = (op[0] == OP_DIV);
    assign div_zero  = start_div && (src_b == '0);

`ifdef MULDIV_SIGNED_EN
    logic             sign_a, sign_b;
    logic [2*WIDTH-1:0] prod_neg;
    assign prod_neg = -{hi_r, lo_r};
`else
    logic unused_op;
    assign unused_op = op[1];
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .hi         (hi_r),
        .lo         (lo_r),
        .opnd       (opnd),
        .alu_result (alu_result),
        .alu_sel    (step_sel),
        .alu_a      (step_a),
        .alu_b      (step_b),
        .hi_nx      (step_hi),
        .lo_nx      (step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        alu_sel  = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            ST_IDLE: if (start) begin
                if (div_zero)
                    state_nx = ST_DONE;
                else
`ifdef MULDIV_SIGNED_EN
                    state_nx = ST_PRE;
`else
                    state_nx = start_div ? ST_DIV : ST_MUL;
`endif
            end
`ifdef MULDIV_SIGNED_EN
            ST_PRE:  state_nx = is_div ? ST_DIV : ST_MUL;
            ST_POST: state_nx = ST_DONE;
`endif
            ST_MUL, ST_DIV: begin
                alu_sel = step_sel;
                alu_a   = step_a;
                alu_b   = step_b;
                if (count == LAST)
`ifdef MULDIV_SIGNED_EN
                    state_nx = ST_POST;
`else
                    state_nx = ST_DONE;
`endif
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // lo starts as the multiplier/dividend so its bits shift out as quotient/product bits shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= '0;
            lo_r   <= '0;
            opnd   <= '0;
            count  <= '0;
            is_div <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    count  <= '0;
                    is_div <= start_div;
                    hi_r   <= '0;
                    lo_r   <= start_div ? src_a : src_b;
                    opnd   <= start_div ? src_b : src_a;
                    if (div_zero) begin
                        hi_r <= src_a;
                        lo_r <= '1;
                    end
`ifdef MULDIV_SIGNED_EN
                    sign_a <= op[1] & src_a[WIDTH-1];
                    sign_b <= op[1] & src_b[WIDTH-1];
`endif
                end
`ifdef MULDIV_SIGNED_EN
                ST_PRE: begin
                    if (is_div ? sign_a : sign_b) lo_r <= -lo_r;
                    if (is_div ? sign_b : sign_a) opnd <= -opnd;
                end
                ST_POST: begin
                    if (!is_div) begin
                        if (sign_a ^ sign_b) {hi_r, lo_r} <= prod_neg;
                    end else begin
                        if (sign_a ^ sign_b) lo_r <= -lo_r;
                        if (sign_a)          hi_r <= -hi_r;
                    end
                end
`endif
                ST_MUL, ST_DIV: begin
                    hi_r  <= step_hi;
                    lo_r  <= step_lo;
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
